ex_md_ctrl: RTL

EX_MD_CTRL -- requirements
Module: ex_md_ctrl

---
 rtl/ex_md_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ex_md_ctrl.sv
// EX-stage mul/div sequencer: start pulse, latency counting, and hold of the result until MEM accepts.
// Ports: clk, rst_n; EX status and ex_rs2_is_zero in; mem_allowin and flush in; ex_allowin, ex_ready_go and md_* out.
// Build option MD_DIV_ZERO_FAST_EN: a divide by zero skips the datapath and completes after one cycle.
module ex_md_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_valid,
  input  logic ex_is_mul_inst,
  input  logic ex_is_div_inst,
  input  logic ex_rs2_is_zero,
  input  logic mem_allowin,
  input  logic flush,
  output logic ex_allowin,
  output logic ex_ready_go,
  output logic md_start,
  output logic md_op,
  output logic md_busy,
  output logic md_done,
  output logic md_dz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [5:0] MUL_LD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_LAT - 1);
  localparam bit MUL_ONE = (MUL_LAT == 1);
  localparam bit DIV_ONE = (DIV_LAT == 1);

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic       r_dz, w_dz_nxt;

  logic w_req;
  logic w_is_div;
  logic w_go;
  logic w_dz_fast;

  assign w_req    = ex_valid & (ex_is_mul_inst | ex_is_div_inst);
  assign w_is_div = ex_is_div_inst;

`ifdef MD_DIV_ZERO_FAST_EN
  assign w_dz_fast = w_is_div & ex_rs2_is_zero;
`else
  logic w_unused;
  assign w_unused  = ex_rs2_is_zero;
  assign w_dz_fast = 1'b0;
`endif

  // A start must also be masked while reset is held, because
  // IDLE together with a request would otherwise pulse it.
  assign w_go = (r_state == S_IDLE) & w_req & ~flush & rst_n;

  assign md_start    = w_go & ~w_dz_fast;
  assign md_op       = (r_state == S_DIV) | (md_start & w_is_div);
  assign md_busy     = (r_state == S_MUL) | (r_state == S_DIV);
  assign md_done     = (r_state == S_DONE);
  assign md_dz       = r_dz;
  assign ex_ready_go = ~w_req | (r_state == S_DONE);
  assign ex_allowin  = ~ex_valid | (ex_ready_go & mem_allowin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  // The counter is loaded with LAT-1. Leaving on the edge where
  // it would decrement to zero makes md_done rise exactly LAT
  // cycles after the start cycle. A latency of 1 goes straight
  // to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dz_nxt    = r_dz;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 6'd0;
      w_dz_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (w_dz_fast) begin
              w_state_nxt = S_DONE;
              w_cnt_nxt   = 6'd0;
              w_dz_nxt    = 1'b1;
            end else if (w_is_div) begin
              w_state_nxt = DIV_ONE ? S_DONE : S_DIV;
              w_cnt_nxt   = DIV_ONE ? 6'd0 : DIV_LD;
            end else begin
              w_state_nxt = MUL_ONE ? S_DONE : S_MUL;
              w_cnt_nxt   = MUL_ONE ? 6'd0 : MUL_LD;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt <= 6'd1) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_cnt_nxt = r_cnt - 6'd1;
          end
        end
        S_DONE: begin
          if (mem_allowin) begin
            w_state_nxt = S_IDLE;
            w_dz_nxt    = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
          w_dz_nxt    = 1'b0;
        end
      endcase
    end
  end

endmodule
